// File: rtl/sm_display_pkg.sv
// Shared types and constants for the sign-magnitude result display.
//   state_t      handshake/conversion FSM states
//   digit_t      per-digit code: 0-9 BCD, DIGIT_BLANK, DIGIT_MINUS
//   seg_pattern  logical 7-segment pattern {g,f,e,d,c,b,a}, 1 = lit
package sm_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_BLANK = 4'hA;
    localparam digit_t DIGIT_MINUS = 4'hB;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_pattern(digit_t d);
        case (d)
            4'd0:        return SEG_0;
            4'd1:        return SEG_1;
            4'd2:        return SEG_2;
            4'd3:        return SEG_3;
            4'd4:        return SEG_4;
            4'd5:        return SEG_5;
            4'd6:        return SEG_6;
            4'd7:        return SEG_7;
            4'd8:        return SEG_8;
            4'd9:        return SEG_9;
            DIGIT_MINUS: return SEG_MINUS;
            default:     return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock.
//   clk, rst_n  clock, async active-low reset
//   start       load bin and begin DATA_WIDTH iterations (ignored-safe only when idle)
//   bin         magnitude to convert, sampled on start
//   done        high during the cycle of the final iteration; bcd is final on the next cycle
//   bcd         {hundreds, tens, ones}
module bin_to_bcd_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bin,
    output logic                  done,
    output logic [11:0]           bcd
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [11:0]           bcd_r;
    logic [11:0]           bcd_adj;
    logic [DATA_WIDTH-1:0] mag_r;
    logic [CW-1:0]         iter_cnt;

    function automatic logic [3:0] add3(logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign bcd_adj = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};

    // Iteration count runs down to zero; zero means idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r    <= '0;
            mag_r    <= '0;
            iter_cnt <= '0;
        end else if (start) begin
            bcd_r    <= '0;
            mag_r    <= bin;
            iter_cnt <= CW'(DATA_WIDTH);
        end else if (iter_cnt != '0) begin
            bcd_r    <= {bcd_adj[10:0], mag_r[DATA_WIDTH-1]};
            mag_r    <= mag_r << 1;
            iter_cnt <= iter_cnt - 1'b1;
        end
    end

    assign done = (iter_cnt == CW'(1));
    assign bcd  = bcd_r;

endmodule

// File: rtl/sm_result_display.sv
// Accepts sign-magnitude results over valid/ready, converts the magnitude to BCD
// and scans the signed decimal value onto a 4-digit multiplexed 7-segment display.
//   clk, rst_n  clock, async active-low reset
//   in_valid    in_data valid
//   in_data     {sign, magnitude}
//   in_ready    accepting (IDLE); busy is its complement
//   an          one-hot digit enable, an[0] = ones digit
//   seg, dp     segments {g..a} and decimal point (always off)
//
//   state   | meaning
//   IDLE    | ready; accept a result on in_valid and start conversion
//   CONVERT | double-dabble iterating, one bit per cycle
//   UPDATE  | copy sign and BCD into the display registers
module sm_result_display
    import sm_display_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_WIDTH:0] in_data,
    output logic                in_ready,
    output logic                busy,
    output logic [3:0]          an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int RW = $clog2(REFRESH_DIV);

    state_t        state, next_state;
    logic          conv_start;
    logic          conv_done;
    logic          load_disp;
    logic [11:0]   conv_bcd;
    logic          sign_r;

    logic          disp_sign;
    logic [11:0]   disp_bcd;
    digit_t        digit_code [4];

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic [3:0]    an_log;
    logic [6:0]    seg_log;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = CONVERT;
            CONVERT: if (conv_done) next_state = UPDATE;
            UPDATE:                 next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        conv_start = (state == IDLE) && in_valid;
        load_disp  = (state == UPDATE);
    end

    assign busy = ~in_ready;

    bin_to_bcd_seq #(.DATA_WIDTH(DATA_WIDTH)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (in_data[DATA_WIDTH-1:0]),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r    <= 1'b0;
            disp_sign <= 1'b0;
            disp_bcd  <= '0;
        end else begin
            if (conv_start) sign_r <= in_data[DATA_WIDTH];
            if (load_disp) begin
                disp_sign <= sign_r;
                disp_bcd  <= conv_bcd;
            end
        end
    end

    // Negative zero shows no minus; tens blanks only when hundreds is blank too.
    always_comb begin
        digit_code[0] = disp_bcd[3:0];
        digit_code[1] = (disp_bcd[11:4] == '0) ? DIGIT_BLANK : disp_bcd[7:4];
        digit_code[2] = (disp_bcd[11:8] == '0) ? DIGIT_BLANK : disp_bcd[11:8];
        digit_code[3] = (disp_sign && disp_bcd != '0) ? DIGIT_MINUS : DIGIT_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            an_log      <= '0;
            seg_log     <= '0;
        end else begin
            if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an_log  <= 4'b0001 << scan_idx;
            seg_log <= seg_pattern(digit_code[scan_idx]);
        end
    end

    assign an  = (AN_ACTIVE_LOW  != 0) ? ~an_log  : an_log;
    assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_log : seg_log;
    assign dp  = (SEG_ACTIVE_LOW != 0);

endmodule
